// File: rtl/avalon_pio_bank.sv
// Multi-channel Avalon PIO bank: NUM_OUT output channels with atomic set/clear, NUM_IN
// synchronised input channels with edge capture and masked irq. Define PIO_DEBOUNCE_EN for input debounce.
module avalon_pio_bank #(
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       NUM_OUT         = 4,
  parameter int unsigned       NUM_IN          = 2,
  parameter int unsigned       EDGE_MODE       = 0,
  parameter logic [DATA_W-1:0] OUT_RESET       = '0,
  parameter int unsigned       DEBOUNCE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                address,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_W-1:0]         writedata,
  output logic [DATA_W-1:0]         readdata,
  output logic [NUM_OUT*DATA_W-1:0] out_export,
  input  logic [NUM_IN*DATA_W-1:0]  in_export,
  output logic                      irq
);

  localparam int unsigned InW = NUM_IN * DATA_W;

  typedef enum logic [2:0] {
    SelData = 3'd0,
    SelSet  = 3'd1,
    SelClr  = 3'd2,
    SelIn   = 3'd4,
    SelMask = 3'd5,
    SelCap  = 3'd6
  } sel_e;

  if (DATA_W < 1 || DATA_W > 32 || NUM_OUT < 1 || NUM_OUT > 32 || NUM_IN < 1 || NUM_IN > 32 ||
      EDGE_MODE > 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("avalon_pio_bank: parameter out of range");
  end

  logic [4:0] chan;
  sel_e       sel;
  assign chan = address[7:3];
  assign sel  = sel_e'(address[2:0]);

  // Output channels
  logic [DATA_W-1:0] data_q [NUM_OUT];
  logic [DATA_W-1:0] data_d [NUM_OUT];

  always_comb begin
    for (int c = 0; c < NUM_OUT; c++) begin
      data_d[c] = data_q[c];
      if (write && chan == 5'(c)) begin
        unique case (sel)
          SelData: data_d[c] = writedata;
          SelSet:  data_d[c] = data_q[c] | writedata;
          SelClr:  data_d[c] = data_q[c] & ~writedata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_OUT; c++) data_q[c] <= OUT_RESET;
    end else begin
      for (int c = 0; c < NUM_OUT; c++) data_q[c] <= data_d[c];
    end
  end

  for (genvar c = 0; c < NUM_OUT; c++) begin : g_out
    assign out_export[c*DATA_W +: DATA_W] = data_q[c];
  end

  // Input channels
  logic [InW-1:0] sync1_q, sync2_q, prev_q, filt;
  logic [InW-1:0] mask_q, mask_d, cap_q, cap_d, w1c;
  logic [InW-1:0] rise, fall, edge_det;
  logic [1:0]     arm_q;
  logic           armed;

`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [InW-1:0]  sync3_q, filt_q, filt_d;
  logic [CntW-1:0] cnt_q [NUM_IN];
  logic [CntW-1:0] cnt_d [NUM_IN];

  // Any change of sync2 restarts the window; filt follows once sync2 has held for the window.
  always_comb begin
    filt_d = filt_q;
    for (int c = 0; c < NUM_IN; c++) begin
      cnt_d[c] = cnt_q[c];
      if (sync2_q[c*DATA_W +: DATA_W] != sync3_q[c*DATA_W +: DATA_W]) begin
        cnt_d[c] = '0;
      end else if (sync2_q[c*DATA_W +: DATA_W] != filt_q[c*DATA_W +: DATA_W]) begin
        if (cnt_q[c] == CntW'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[c*DATA_W +: DATA_W] = sync2_q[c*DATA_W +: DATA_W];
          cnt_d[c]                   = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync3_q <= '0;
      filt_q  <= '0;
      for (int c = 0; c < NUM_IN; c++) cnt_q[c] <= '0;
    end else begin
      sync3_q <= sync2_q;
      filt_q  <= filt_d;
      for (int c = 0; c < NUM_IN; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  assign rise     = filt & ~prev_q;
  assign fall     = ~filt & prev_q;
  assign edge_det = (EDGE_MODE == 0) ? rise : (EDGE_MODE == 1) ? fall : (rise | fall);
  // Edges are ignored while the synchroniser/history pipeline fills after reset.
  assign armed    = (arm_q == 2'd3);

  always_comb begin
    w1c    = '0;
    mask_d = mask_q;
    for (int c = 0; c < NUM_IN; c++) begin
      if (write && chan == 5'(c)) begin
        if (sel == SelMask) mask_d[c*DATA_W +: DATA_W] = writedata;
        if (sel == SelCap)  w1c[c*DATA_W +: DATA_W]    = writedata;
      end
    end
    // A fresh edge beats a simultaneous W1C on the same bit.
    cap_d = (cap_q & ~w1c) | (armed ? edge_det : '0);
  end

  // Read mux; unmapped or reserved selects read as zero.
  logic [DATA_W-1:0] rdata;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_OUT; c++) begin
      if (chan == 5'(c) && sel == SelData) rdata = data_q[c];
    end
    for (int c = 0; c < NUM_IN; c++) begin
      if (chan == 5'(c)) begin
        unique case (sel)
          SelIn:   rdata = filt[c*DATA_W +: DATA_W];
          SelMask: rdata = mask_q[c*DATA_W +: DATA_W];
          SelCap:  rdata = cap_q[c*DATA_W +: DATA_W];
          default: ;
        endcase
      end
    end
  end

  logic [DATA_W-1:0] readdata_q;
  logic              irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      arm_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q <= in_export;
      sync2_q <= sync1_q;
      prev_q  <= filt;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      if (!armed) arm_q <= arm_q + 2'd1;
      if (read) readdata_q <= rdata;
      irq_q <= |(cap_q & mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed bench for avalon_pio_bank (default build): expected values go through a
// scoreboard queue and are checked with immediate assertions.
module tb_avalon_pio_bank;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned NUM_IN  = 2;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [7:0]                address;
  logic                      read;
  logic                      write;
  logic [DATA_W-1:0]         writedata;
  logic [DATA_W-1:0]         readdata;
  logic [NUM_OUT*DATA_W-1:0] out_export;
  logic [NUM_IN*DATA_W-1:0]  in_export;
  logic                      irq;

  avalon_pio_bank #(
    .DATA_W         (DATA_W),
    .NUM_OUT        (NUM_OUT),
    .NUM_IN         (NUM_IN),
    .EDGE_MODE      (0),
    .OUT_RESET      (32'h0),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .out_export(out_export),
    .in_export (in_export),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (val_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_check(obs);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read = 1'b0;
    sb_check(readdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    in_export = 64'h2;  // bit1 of ch0 already high at reset release
    @(negedge clk);
    chk_now("rst_out0", out_export[31:0], 32'h0);
    chk_now("rst_out1", out_export[63:32], 32'h0);
    chk_now("rst_readdata", readdata, 32'h0);
    chk_now("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(4);

    rd(8'h06, 32'h0, "arm_no_capture");
    rd(8'h04, 32'h2, "in_ch0");

    // Output writes, set, clear
    wr(8'h08, 32'hA5A5_0000);
    chk_now("ch1_out", out_export[63:32], 32'hA5A5_0000);
    rd(8'h08, 32'hA5A5_0000, "ch1_rd");
    wr(8'h00, 32'h0000_00F0);
    chk_now("ch0_data", out_export[31:0], 32'h0000_00F0);
    wr(8'h01, 32'h0000_000F);
    chk_now("ch0_set", out_export[31:0], 32'h0000_00FF);
    wr(8'h02, 32'h0000_0030);
    chk_now("ch0_clr", out_export[31:0], 32'h0000_00CF);
    rd(8'h01, 32'h0, "set_rd_zero");
    rd(8'h00, 32'h0000_00CF, "ch0_rd");
    tick(1);
    chk_now("rd_hold", readdata, 32'h0000_00CF);

    // Rising edge capture and irq timing
    wr(8'h05, 32'h1);
    rd(8'h05, 32'h1, "mask_rd");
    in_export[0] = 1'b1;
    tick(2);
    rd(8'h06, 32'h0, "cap_before_k2");
    chk_now("irq_pre", {31'b0, irq}, 32'h0);
    rd(8'h06, 32'h1, "cap_at_k2");
    chk_now("irq_rise", {31'b0, irq}, 32'h1);
    wr(8'h06, 32'h1);
    tick(1);
    chk_now("irq_fall", {31'b0, irq}, 32'h0);
    rd(8'h06, 32'h0, "cap_w1c");

    // Falling edge ignored in rising mode; then W1C colliding with a new rise
    in_export[0] = 1'b0;
    tick(4);
    rd(8'h06, 32'h0, "fall_ignored");
    in_export[0] = 1'b1;
    tick(2);
    in_export[0] = 1'b0;
    tick(2);
    in_export[0] = 1'b1;
    tick(2);
    wr(8'h06, 32'h1);
    chk_now("irq_collide", {31'b0, irq}, 32'h1);
    rd(8'h06, 32'h1, "cap_collide");
    chk_now("irq_collide_hold", {31'b0, irq}, 32'h1);
    wr(8'h06, 32'h1);
    tick(1);
    chk_now("irq_clear2", {31'b0, irq}, 32'h0);

    // Invalid and reserved accesses
    rd(8'h14, 32'h0, "rd_in_ch2");
    rd(8'h03, 32'h0, "rd_sel3");
    rd(8'h20, 32'h0, "rd_out_ch4");
    wr(8'h14, 32'hFFFF_FFFF);
    wr(8'h03, 32'hFFFF_FFFF);
    wr(8'h20, 32'hFFFF_FFFF);
    wr(8'h15, 32'hFFFF_FFFF);
    wr(8'h07, 32'hFFFF_FFFF);
    wr(8'hFF, 32'hFFFF_FFFF);
    chk_now("inv_out0", out_export[31:0], 32'h0000_00CF);
    chk_now("inv_out1", out_export[63:32], 32'hA5A5_0000);
    chk_now("inv_out2", out_export[95:64], 32'h0);
    chk_now("inv_out3", out_export[127:96], 32'h0);
    rd(8'h05, 32'h1, "inv_mask0");
    rd(8'h0D, 32'h0, "inv_mask1");
    rd(8'h06, 32'h0, "inv_cap0");
    chk_now("inv_irq", {31'b0, irq}, 32'h0);

    // Simultaneous read and write returns the old value
    sb_push("rw_old", 32'h0);
    address   = 8'h10;
    writedata = 32'h1234_5678;
    write     = 1'b1;
    read      = 1'b1;
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    sb_check(readdata);
    chk_now("rw_out2", out_export[95:64], 32'h1234_5678);
    rd(8'h10, 32'h1234_5678, "rw_new");

    // Reset mid-operation discards the in-flight read
    address = 8'h08;
    read    = 1'b1;
    @(posedge clk);
    #2;
    read    = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_now("mid_rst_rd", readdata, 32'h0);
    chk_now("mid_rst_out1", out_export[63:32], 32'h0);
    chk_now("mid_rst_out2", out_export[95:64], 32'h0);
    chk_now("mid_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(4);
    rd(8'h06, 32'h0, "rst_cap_armed");
    rd(8'h05, 32'h0, "rst_mask");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_pio_bank.md
Name: avalon_pio_bank

Overview:
- Parametrised multi-channel PIO peripheral on the PCIe-to-Avalon bridge; it replaces the separate fixed 32-bit hex, led, button and input PIO instances.
- Provides NUM_OUT output channels and NUM_IN input channels, each DATA_W bits wide.
- Input channels have a 2-flop synchroniser, per-bit edge capture, and a masked level interrupt.
- Output channels support atomic bit set and bit clear.

Parameters:
- DATA_W, 32: channel width in bits, 1..32.
- NUM_OUT, 4: number of output channels, 1..32.
- NUM_IN, 2: number of input channels, 1..32.
- EDGE_MODE, 0: edge-capture trigger. 0 = rising, 1 = falling, 2 = any edge.
- OUT_RESET, 0: reset value of every output channel, DATA_W bits.
- DEBOUNCE_CYCLES, 16: stability window in cycles. Used only when PIO_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on this single clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  8  word address. Bits [7:3] = channel index, bits [2:0] = register select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  DATA_W  write data.
- readdata  out  DATA_W  read data, fixed read latency of 1.
- out_export  out  NUM_OUT*DATA_W  output channels; channel c occupies bits [c*DATA_W +: DATA_W].
- in_export  in  NUM_IN*DATA_W  asynchronous input channels, same packing as out_export.
- irq  out  1  level interrupt.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - out_export = OUT_RESET replicated per channel.
  - readdata = 0, irq = 0.
  - All mask, capture, synchroniser and history flops = 0.
- Register map per channel c (from address[7:3]):
  - sel 0: DATA (RW, output channel).
  - sel 1: SET (WO); data |= writedata.
  - sel 2: CLR (WO); data &= ~writedata.
  - sel 4: IN (RO, synchronised/filtered input value).
  - sel 5: MASK (RW).
  - sel 6: CAPTURE (RW1C).
  - sel 3 and sel 7 are reserved.
- Invalid accesses: reserved selects, output selects with c >= NUM_OUT, and input selects with c >= NUM_IN. Reads of these return 0; writes to them are ignored. Reads of SET and CLR return 0.
- Write timing: a write takes effect at the clock edge where write=1; out_export changes in that same cycle. No waitrequest is generated.
- Read timing: readdata is registered at the edge where read=1 and is valid the following cycle. When read=0, readdata holds its last value.
- Simultaneous read and write: the read returns the pre-write value.
- Input synchroniser: sync1 <= in_export, then sync2 <= sync1, then prev <= filtered. The filtered value equals sync2 when debounce is compiled out.
- Edge detect per bit:
  - rise = filtered & ~prev.
  - fall = ~filtered & prev.
  - EDGE_MODE selects rise, fall, or rise|fall.
- Edge timing: an input change settled before edge k sets CAPTURE at edge k+2, so it is visible to a read issued in cycle k+3.
- Arming: edge detection is disarmed for the first 3 cycles after reset_n deasserts while the pipeline fills. Inputs already high at reset release therefore do not set CAPTURE.
- CAPTURE update: capture <= (capture & ~w1c) | edge.
  - If an edge and a W1C on the same bit occur in the same cycle, the set wins.
  - A W1C of 0 bits has no effect.
- Interrupt: irq = OR over all input channels of (CAPTURE & MASK). It is driven from registered state, so it is glitch-free.
  - irq rises the cycle after CAPTURE is set with its MASK bit high.
  - irq falls the cycle after the W1C or mask write that clears the last pending bit.
- Mid-operation reset: asserting reset_n low mid-operation immediately returns all state to the reset values, and any in-flight read is discarded.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- Defined: each input channel has a counter of width clog2(DEBOUNCE_CYCLES)+1 and a filtered register.
  - The counter resets to 0 whenever sync2 differs from its previous-cycle value, and increments while sync2 != filtered.
  - When the counter reaches DEBOUNCE_CYCLES-1, filtered <= sync2.
  - IN and edge detection use filtered. Filtered resets to 0.
- Not defined: filtered = sync2 combinationally, no counters are built, and DEBOUNCE_CYCLES is ignored.

Test Plan:
- Write 0xA5A5_0000 to ch1 DATA (address 0x08) -> out_export[63:32] = 0xA5A50000 the same cycle; a read of 0x08 returns 0xA5A50000 after 1 cycle.
- ch0 DATA = 0x0000_00F0, then SET 0x0F (address 0x01), then CLR 0x30 (address 0x02) -> out_export[31:0] = 0xFF, then 0xCF.
- EDGE_MODE=0, MASK ch0 = 0x1. Drive in_export bit0 0->1 -> CAPTURE ch0 = 0x1 at edge k+2 and irq = 1 one cycle later. Write 0x1 to address 0x06 -> irq = 0 next cycle.
- A W1C of bit0 in the same cycle as a new rising edge on bit0 -> CAPTURE bit0 stays 1 and irq stays 1.
- With NUM_IN=2: read address 0x14 (input ch2) and address 0x03 (reserved) -> both return 0; writes to them leave all state unchanged.
- With PIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - A 10-cycle glitch on bit0 -> IN stays 0 and no capture.
  - A held 1 -> IN = 1 after 2+16 cycles, and CAPTURE is set 1 cycle later.
